// File: rtl/gsm_switch_pkg.sv
// Shared switch definitions: RAM latencies, default cell-queue geometry and a pointer helper.
package gsm_switch_pkg;
    localparam int unsigned RAM_RD_LAT  = 2;
    localparam int unsigned RAM_WR_LAT  = 2;
    localparam int unsigned CELL_DWIDTH = 18;
    localparam int unsigned CELL_AWIDTH = 10;

    // Modular difference a - b of two wrap-around pointers that are w bits wide (w < 32).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction
endpackage

// File: rtl/infer_sdpram.sv
// Simple dual-port RAM: port A writes commit one cycle after the request,
// port B reads return data two cycles after the request and hold while idle.
module infer_sdpram #(
    parameter int unsigned DWIDTH = 18,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk_a,
    input  logic              en_a,
    input  logic              write_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] wr_data_a,
    input  logic              clk_b,
    input  logic              en_b,
    input  logic [AWIDTH-1:0] addr_b,
    output logic [DWIDTH-1:0] rd_data_b
);
    localparam int unsigned DEPTH = 2**AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic              r_wr_en;
    logic [AWIDTH-1:0] r_wr_addr;
    logic [DWIDTH-1:0] r_wr_data;
    logic              r_rd_en;
    logic [AWIDTH-1:0] r_rd_addr;

    always_ff @(posedge clk_a) begin
        r_wr_en <= en_a & write_a;
        if (en_a & write_a) begin
            r_wr_addr <= addr_a;
            r_wr_data <= wr_data_a;
        end
        if (r_wr_en) r_mem[r_wr_addr] <= r_wr_data;
    end

    always_ff @(posedge clk_b) begin
        r_rd_en <= en_b;
        if (en_b) r_rd_addr <= addr_b;
        if (r_rd_en) rd_data_b <= r_mem[r_rd_addr];
    end
endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// First-word-fall-through cell FIFO over one SDP RAM; a small prefetch buffer
// hides the RAM write-commit and read latencies from both handshakes.
module sdpram_fifo_ctrl
    import gsm_switch_pkg::*;
#(
    parameter int unsigned DWIDTH = CELL_DWIDTH,
    parameter int unsigned AWIDTH = CELL_AWIDTH,
    parameter int unsigned PBUF   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH+1:0] level,
    output logic              empty
);
    localparam int unsigned DEPTH = 2**AWIDTH;
    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned LW    = AWIDTH + 2;
    localparam int unsigned BIW   = $clog2(PBUF);
    localparam int unsigned BCW   = $clog2(PBUF + 1);
    localparam int unsigned PDW   = BCW + 1;

    logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_commit_ptr;
    logic              r_acc_d1, r_v1, r_v2;
    logic [DWIDTH-1:0] r_buf [PBUF];
    logic [BIW-1:0]    r_bwr, r_brd;
    logic [BCW-1:0]    r_bcnt;
    logic              r_in_ready, r_out_valid, r_empty;
    logic [LW-1:0]     r_level;

    logic              w_accept, w_issue, w_pop;
    logic [PW-1:0]     w_wr_ptr_n, w_rd_ptr_n, w_ram_used_n;
    logic [PDW-1:0]    w_pend;
    logic [BCW-1:0]    w_bcnt_n;
    logic [LW-1:0]     w_level_n;
    logic [BIW-1:0]    w_bwr_n, w_brd_n;
    logic [DWIDTH-1:0] w_rd_data;

    infer_sdpram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
        .clk_a     (clk),
        .en_a      (w_accept),
        .write_a   (w_accept),
        .addr_a    (r_wr_ptr[AWIDTH-1:0]),
        .wr_data_a (in_data),
        .clk_b     (clk),
        .en_b      (w_issue),
        .addr_b    (r_rd_ptr[AWIDTH-1:0]),
        .rd_data_b (w_rd_data)
    );

    // Handshakes, read issue and next values of the registered status outputs.
    always_comb begin
        w_accept     = in_valid & r_in_ready;
        w_pop        = r_out_valid & out_ready;
        w_pend       = PDW'(r_v1) + PDW'(r_v2) + PDW'(r_bcnt);
        w_issue      = (r_rd_ptr != r_commit_ptr) && (w_pend < PDW'(PBUF));
        w_wr_ptr_n   = r_wr_ptr + PW'(w_accept);
        w_rd_ptr_n   = r_rd_ptr + PW'(w_issue);
        w_ram_used_n = PW'(ptr_diff(32'(w_wr_ptr_n), 32'(w_rd_ptr_n), PW));
        w_bcnt_n     = r_bcnt + BCW'(r_v2) - BCW'(w_pop);
        w_level_n    = LW'(w_ram_used_n) + LW'(w_issue) + LW'(r_v1) + LW'(w_bcnt_n);
        w_bwr_n      = (r_bwr == BIW'(PBUF - 1)) ? '0 : r_bwr + BIW'(1);
        w_brd_n      = (r_brd == BIW'(PBUF - 1)) ? '0 : r_brd + BIW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_acc_d1     <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_bwr        <= '0;
            r_brd        <= '0;
            r_bcnt       <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_empty      <= 1'b1;
            r_level      <= '0;
            for (int i = 0; i < int'(PBUF); i++) r_buf[i] <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_acc_d1 <= w_accept;
            // An entry becomes readable once its RAM write has committed.
            if (r_acc_d1) r_commit_ptr <= r_commit_ptr + PW'(1);
            r_v1 <= w_issue;
            r_v2 <= r_v1;
            if (r_v2) begin
                r_buf[r_bwr] <= w_rd_data;
                r_bwr        <= w_bwr_n;
            end
            if (w_pop) r_brd <= w_brd_n;
            r_bcnt      <= w_bcnt_n;
            r_in_ready  <= (w_ram_used_n != PW'(DEPTH));
            r_out_valid <= (w_bcnt_n != '0);
            r_empty     <= (w_level_n == '0);
            r_level     <= w_level_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_buf[r_brd];
    assign level     = r_level;
    assign empty     = r_empty;
endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Bench for sdpram_fifo_ctrl: directed steps plus randomized traffic against a queue model.
module tb_sdpram_fifo_ctrl;
    localparam int unsigned DW    = 18;
    localparam int unsigned AW    = 4;
    localparam int unsigned PB    = 4;
    localparam int unsigned DEPTH = 2**AW;

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, empty;
    logic [DW-1:0] in_data, out_data;
    logic [AW+1:0] level;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] q[$];
    logic          acc, pop;

    sdpram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .PBUF(PB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare the head, advance the model, compare occupancy.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        pop = out_valid & out_ready;
        if (out_valid) begin
            check("head_present", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("head_data", 32'(out_data), 32'(q[0]));
        end
        @(posedge clk);
        cyc++;
        if (rst) q.delete();
        else begin
            if (pop && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        @(negedge clk);
        check("level", 32'(level), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("level_bound", 32'(int'(level) <= int'(DEPTH + PB)), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int          acc_cyc, first, n, wr_cnt, words;
        logic        iv, ordy;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_out_data",  32'(out_data),  32'd0);

        // Single word: five-cycle empty-to-out latency, then pop.
        acc_cyc = cyc;
        step(1'b1, 18'h155, 1'b1);
        check("t1_accept", 32'(acc), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin step(1'b0, '0, 1'b1); n++; end
        check("t1_latency", 32'(cyc - acc_cyc), 32'd5);
        check("t1_data", 32'(out_data), 32'h155);
        step(1'b0, '0, 1'b1);
        check("t1_level_after_pop", 32'(level), 32'd0);

        // Fill RAM plus prefetch buffer with the output stalled.
        wr_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, DW'(wr_cnt), 1'b0);
            if (acc) wr_cnt++;
        end
        check("t2_words", 32'(wr_cnt), 32'(DEPTH + PB));
        check("t2_level", 32'(level), 32'(DEPTH + PB));
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_empty", 32'(empty), 32'd0);
        drain();

        // Continuous streaming across several pointer wraps.
        wr_cnt = 0;
        for (int i = 0; i < 4 * int'(DEPTH) + 16; i++) begin
            step(1'b1, DW'(wr_cnt + 1000), 1'b1);
            if (acc) wr_cnt++;
            if (i >= 10) begin
                check("t3_accept", 32'(acc), 32'd1);
                check("t3_pop", 32'(pop), 32'd1);
            end
        end
        drain();

        // Randomized traffic against the model.
        words = 0; n = 0;
        while (words < 10000 && n < 40000) begin
            iv   = ($urandom_range(0, 99) < 70);
            ordy = 1'($urandom_range(0, 1));
            step(iv, DW'($urandom), ordy);
            if (acc) words++;
            n++;
        end
        check("t4_words", 32'(words), 32'd10000);
        drain();

        // Reset while reads are in flight and the buffer holds entries.
        for (int i = 0; i < 6; i++) step(1'b1, DW'(32'h100 + i), 1'b0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_empty", 32'(empty), 32'd1);
        step(1'b1, 18'h3, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin step(1'b0, '0, 1'b1); n++; end
        check("t5_first_out", 32'(out_data), 32'h3);
        drain();

        // Push and pop every cycle starting from empty.
        acc_cyc = cyc; first = -1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && first < 0) first = cyc;
            step(1'b1, DW'(32'h2A0 + i), 1'b1);
        end
        check("t6_latency", 32'(first - acc_cyc), 32'd5);
        drain();
        check("final_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
